qpsk_deframer: RTL and testbench



---
 rtl/qpsk_link_pkg.sv | 16 +
 rtl/deframe_sync_detect.sv | 46 ++++
 rtl/qpsk_deframer.sv | 107 ++++++++++
 tb/tb_qpsk_deframer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/qpsk_link_pkg.sv
// Shared QPSK link constants and the deframer state type.
// The dibit serializer on the transmit side uses the same definitions.
package qpsk_link_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } deframe_state_e;

    localparam int SYM_W      = 2;
    localparam int FRAME_SYMS = 14;
    localparam int FRAME_W    = SYM_W * FRAME_SYMS;
    localparam int SYNC_LEN   = 8;
    localparam logic [15:0] SYNC_WORD = 16'h1ACF;

endpackage

// File: rtl/deframe_sync_detect.sv
// Preamble detector: shifts accepted dibits into a window and flags the symbol
// that completes SYNC_WORD once the window holds SYNC_LEN fresh symbols.
module deframe_sync_detect
    import qpsk_link_pkg::*;
#(
    parameter int SYM_W_P    = SYM_W,
    parameter int SYNC_LEN_P = SYNC_LEN,
    parameter logic [SYNC_LEN_P*SYM_W_P-1:0] SYNC_WORD_P = SYNC_WORD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic [SYM_W_P-1:0] sym,
    input  logic               clear,
    output logic               match
);

    localparam int SR_W   = SYM_W_P * SYNC_LEN_P;
    localparam int FILL_W = $clog2(SYNC_LEN_P + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_LEN_P);

    logic [SR_W-1:0]   sync_sr_q, sync_sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;

    // Match is judged on the post-shift window so the FSM leaves HUNT on the
    // same edge that samples the final preamble symbol.
    always_comb begin
        sync_sr_d = {sync_sr_q[SR_W-SYM_W_P-1:0], sym};
        fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        match     = shift_en && (fill_d == FILL_FULL) && (sync_sr_d == SYNC_WORD_P);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_sr_q <= '0;
            fill_q    <= '0;
        end else if (clear) begin
            sync_sr_q <= '0;
            fill_q    <= '0;
        end else if (shift_en) begin
            sync_sr_q <= sync_sr_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/qpsk_deframer.sv
// QPSK receive deframer: collects FRAME_SYMS dibits LSB-first into a codeword
// behind a valid/ready register. Define DEFRAME_SYNC_EN to hunt a preamble first.
module qpsk_deframer #(
    parameter int SYM_W      = qpsk_link_pkg::SYM_W,
    parameter int FRAME_SYMS = qpsk_link_pkg::FRAME_SYMS
`ifdef DEFRAME_SYNC_EN
    ,
    parameter int SYNC_LEN   = qpsk_link_pkg::SYNC_LEN,
    parameter logic [SYNC_LEN*SYM_W-1:0] SYNC_WORD = qpsk_link_pkg::SYNC_WORD
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sym_valid,
    input  logic [SYM_W-1:0]            sym_data,
    input  logic                        frame_ready,
    output logic                        frame_valid,
    output logic [SYM_W*FRAME_SYMS-1:0] frame_data,
    output logic                        overflow,
    output logic [7:0]                  drop_cnt
);
    import qpsk_link_pkg::*;

    localparam int FRM_W = SYM_W * FRAME_SYMS;
    localparam int CNT_W = $clog2(FRAME_SYMS);
    localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(FRAME_SYMS - 1);

    deframe_state_e    state_q;
    logic [CNT_W-1:0]  sym_cnt_q;
    logic [FRM_W-1:0]  buf_q, frame_d;
    logic              frame_valid_q;
    logic [FRM_W-1:0]  frame_data_q;
    logic              overflow_q;
    logic [7:0]        drop_cnt_q;

    logic collect_en, complete, load, drain;

    always_comb begin
        collect_en = sym_valid && (state_q == COLLECT);
        complete   = collect_en && (sym_cnt_q == LAST_SYM);
        drain      = frame_valid_q && frame_ready;
        load       = complete && (!frame_valid_q || frame_ready);
        frame_d    = buf_q;
        frame_d[int'(sym_cnt_q)*SYM_W +: SYM_W] = sym_data;
    end

`ifdef DEFRAME_SYNC_EN
    localparam deframe_state_e RESET_STATE = HUNT;
    logic sync_match;

    deframe_sync_detect #(
        .SYM_W_P     (SYM_W),
        .SYNC_LEN_P  (SYNC_LEN),
        .SYNC_WORD_P (SYNC_WORD)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .shift_en (sym_valid && (state_q == HUNT)),
        .sym      (sym_data),
        .clear    (complete),
        .match    (sync_match)
    );
`else
    localparam deframe_state_e RESET_STATE = COLLECT;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RESET_STATE;
            sym_cnt_q     <= '0;
            buf_q         <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
        end else begin
`ifdef DEFRAME_SYNC_EN
            if (complete)
                state_q <= HUNT;
            else if (sync_match)
                state_q <= COLLECT;
`endif
            if (collect_en) begin
                buf_q     <= frame_d;
                sym_cnt_q <= complete ? '0 : sym_cnt_q + 1'b1;
            end

            // A completing frame may replace one that is leaving this same cycle.
            if (load) begin
                frame_valid_q <= 1'b1;
                frame_data_q  <= frame_d;
            end else if (drain) begin
                frame_valid_q <= 1'b0;
            end

            overflow_q <= complete && !load;
            if (complete && !load && (drop_cnt_q != 8'hFF))
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_qpsk_deframer.sv
// Directed bench for qpsk_deframer; builds with or without DEFRAME_SYNC_EN.
`timescale 1ns/1ps
module tb_qpsk_deframer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sym_valid = 1'b0;
    logic [1:0]  sym_data = 2'b00;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [27:0] frame_data;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;

    qpsk_deframer dut (
        .clk         (clk),
        .rst         (rst),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic send_sym(input logic [1:0] d);
        sym_valid = 1'b1;
        sym_data  = d;
        @(posedge clk); #1;
        sym_valid = 1'b0;
    endtask

    task automatic idle();
        sym_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_preamble();
`ifdef DEFRAME_SYNC_EN
        logic [15:0] w;
        w = 16'h1ACF;
        for (int i = 7; i >= 0; i--) send_sym(w[2*i +: 2]);
`endif
    endtask

    // Dibits first..last of frame f, LSB-first; optional idle after every third.
    task automatic send_dibits(input logic [27:0] f, input int first, input int last, input bit gaps);
        for (int k = first; k <= last; k++) begin
            send_sym(f[2*k +: 2]);
            if (gaps && (k % 3 == 1) && (k != last)) begin
                idle();
                idle();
            end
        end
    endtask

    task automatic send_frame(input logic [27:0] f);
        send_preamble();
        send_dibits(f, 0, 13, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data",  32'(frame_data),  32'd0);
        check("rst_ovf",   32'(overflow),    32'd0);
        check("rst_drop",  32'(drop_cnt),    32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle();

        // Basic frame at full rate with ready high
        frame_ready = 1'b1;
        send_preamble();
        send_dibits(28'h5A3C96E, 0, 12, 1'b0);
        check("a_early_valid", 32'(frame_valid), 32'd0);
        send_dibits(28'h5A3C96E, 13, 13, 1'b0);
        check("a_valid", 32'(frame_valid), 32'd1);
        check("a_data",  32'(frame_data),  32'h5A3C96E);
        check("a_ovf",   32'(overflow),    32'd0);
        idle();
        check("a_drained", 32'(frame_valid), 32'd0);

        // Same frame with sym_valid gaps
        send_preamble();
        send_dibits(28'h5A3C96E, 0, 12, 1'b1);
        check("b_early_valid", 32'(frame_valid), 32'd0);
        idle();
        send_dibits(28'h5A3C96E, 13, 13, 1'b0);
        check("b_valid", 32'(frame_valid), 32'd1);
        check("b_data",  32'(frame_data),  32'h5A3C96E);
        idle();

`ifdef DEFRAME_SYNC_EN
        // Garbage and a corrupted preamble must not open a frame
        begin
            logic [1:0] junk [13];
            junk = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd1,
                     2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd3, 2'd3};
            foreach (junk[i]) send_sym(junk[i]);
        end
        send_preamble();
        check("c_no_frame", 32'(frame_valid), 32'd0);
        send_dibits(28'h3C3C3C3, 0, 13, 1'b0);
        check("c_valid", 32'(frame_valid), 32'd1);
        check("c_data",  32'(frame_data),  32'h3C3C3C3);
        idle();
`endif

        // Overflow: two frames while ready is low
        frame_ready = 1'b0;
        send_frame(28'h1234567);
        check("d_first_valid", 32'(frame_valid), 32'd1);
        check("d_first_data",  32'(frame_data),  32'h1234567);
        send_frame(28'h7654321);
        check("d_ovf_pulse", 32'(overflow),   32'd1);
        check("d_drop",      32'(drop_cnt),   32'd1);
        check("d_held_data", 32'(frame_data), 32'h1234567);
        idle();
        check("d_ovf_end", 32'(overflow), 32'd0);
        frame_ready = 1'b1;
        idle();
        check("d_accepted", 32'(frame_valid), 32'd0);

        // Completion coinciding with the drain of a held frame
        frame_ready = 1'b0;
        send_frame(28'h0ABCDEF);
        check("e_held_data", 32'(frame_data), 32'h0ABCDEF);
        send_preamble();
        send_dibits(28'h2468ACE, 0, 12, 1'b0);
        frame_ready = 1'b1;
        send_dibits(28'h2468ACE, 13, 13, 1'b0);
        check("e_valid", 32'(frame_valid), 32'd1);
        check("e_data",  32'(frame_data),  32'h2468ACE);
        check("e_ovf",   32'(overflow),    32'd0);
        check("e_drop",  32'(drop_cnt),    32'd1);
        idle();
        check("e_drained", 32'(frame_valid), 32'd0);

        // Reset mid-frame with a held frame in the output register
        frame_ready = 1'b0;
        send_frame(28'h1111111);
        send_preamble();
        send_dibits(28'h6666666, 0, 6, 1'b0);
        rst = 1'b0;
        #2;
        check("f_rst_valid", 32'(frame_valid), 32'd0);
        check("f_rst_data",  32'(frame_data),  32'd0);
        check("f_rst_drop",  32'(drop_cnt),    32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        frame_ready = 1'b1;
        send_frame(28'h0F0F0F5);
        check("f_valid", 32'(frame_valid), 32'd1);
        check("f_data",  32'(frame_data),  32'h0F0F0F5);
        check("f_ovf",   32'(overflow),    32'd0);
        idle();
        check("f_drained", 32'(frame_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
